nw_strategy_arbiter: RTL and testbench
======================================

Name: nw_strategy_arbiter

Overview:
- Parametrised N-channel valid/ready arbiter. The arbitration strategy is chosen at run time from fixed-priority, round-robin or weighted round-robin.
- It is the RTL counterpart of the team's strategy pattern: one datapath with interchangeable selection policies.
- It merges NUM_CH request streams into one registered output stream. It sits in front of shared sinks (bus masters, shared FIFOs, scoreboard taps).

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 32, payload width per channel.
- WEIGHT_W, 4, width of each per-channel weight and of the burst counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode_i  in  2  requested strategy: 0 = fixed priority, 1 = round-robin, 2 = weighted RR, 3 = reserved (behaves as 0).
- weights_i  in  NUM_CH*WEIGHT_W  per-channel weights for mode 2; channel i is at [i*WEIGHT_W +: WEIGHT_W].
- in_valid_i  in  NUM_CH  per-channel request valid.
- in_data_i  in  NUM_CH*DATA_W  per-channel payload.
- in_ready_o  out  NUM_CH  per-channel accept; at most one bit high.
- out_valid_o  out  1  output beat valid.
- out_data_o  out  DATA_W  output payload.
- out_ch_o  out  $clog2(NUM_CH)  source channel of the output beat.
- out_ready_i  in  1  downstream accept.
- mode_active_o  out  2  strategy currently in force.

Behaviour:
- Reset (async assert, sync deassert): out_valid_o=0, out_data_o=0, out_ch_o=0, mode_active_o=0, ptr=0, cnt=0. in_ready_o is forced to 0 while rst_n is low. A beat held in the register at reset is discarded.
- Output register: one entry, with two states.
  - EMPTY: out_valid_o=0.
  - FULL: out_valid_o=1.
- Load condition: load_en = !out_valid_o || out_ready_i.
- Grant: computed combinationally from in_valid_i, mode_active_o, ptr and cnt.
  - in_ready_o[g] = load_en && any(in_valid_i).
  - All other in_ready_o bits are 0.
  - Transfer on channel g occurs when in_valid_i[g] && in_ready_o[g].
- Register update on each clock:
  - Transfer: register <= data[g], out_ch_o <= g, state FULL.
  - Output accepted and no transfer: state EMPTY.
  - Otherwise: hold.
- Latency and throughput: input accepted at cycle t appears on the output at t+1. Throughput is one beat per cycle under continuous out_ready_i.
- While FULL and out_ready_i=0: out_data_o and out_ch_o are stable and in_ready_o is all-zero.
- Mode 0 (fixed priority): the lowest-index valid channel wins. ptr and cnt are unused and held.
- Mode 1 (round-robin):
  - Search starts at ptr and wraps modulo NUM_CH; the first valid channel wins.
  - On transfer from g: ptr <= (g+1) mod NUM_CH.
- Mode 2 (weighted RR):
  - Search is the same as mode 1.
  - Effective weight w = max(weights_i[g], 1), sampled live at grant time.
  - Let c = (g==ptr) ? cnt : 0.
  - On transfer: if c >= w-1 then ptr <= (g+1) mod NUM_CH, cnt <= 0; else ptr <= g, cnt <= c+1.
  - A channel whose turn is current but which drops in_valid loses the rest of its burst.
- Mode switch:
  - mode_active_o <= mode_i only in a cycle where out_valid_o==0 and in_valid_i==0.
  - On that update ptr <= 0 and cnt <= 0.
  - Otherwise the change is deferred indefinitely. This is intentional; software must drain the arbiter first.
- Arithmetic: ptr is $clog2(NUM_CH) bits. Wrap is explicit, so non-power-of-two NUM_CH is valid. cnt saturates by construction because c < w <= 2^WEIGHT_W-1.
- Simultaneous accept and load in the same cycle is legal and keeps out_valid_o=1 with no bubble.
- Grant is independent of in_data_i. Payload X on non-granted channels must not propagate.

Test Plan:
- Mode 0, all 4 channels valid continuously, out_ready_i=1 -> out_ch_o = 0,0,0,...; in_ready_o=4'b0001 every cycle.
- Mode 1, all valid, out_ready_i=1 -> out_ch_o = 0,1,2,3,0,1; drop channel 2 valid -> sequence 0,1,3,0,1,3.
- Mode 2, weights {ch0=3, ch1=1, ch2=2, ch3=0}, all valid -> out_ch_o = 0,0,0,1,2,2,3,0,0,0.
- Backpressure: FULL with out_data_o=0xA5A5_0001, out_ready_i low for 5 cycles -> out_data_o/out_ch_o stable, in_ready_o=0, no beat lost or duplicated after release (count in == count out).
- Mode change: mode_i 0->1 while in_valid_i busy -> mode_active_o stays 0. One idle cycle (no valid, EMPTY) -> mode_active_o=1 next cycle, ptr=0.
- Reset: assert rst_n=0 while FULL mid-burst in mode 2 -> out_valid_o=0 and in_ready_o=0 immediately (async). After release, mode_active_o=0 and the first grant is the lowest valid index.

Source files
------------

// File: rtl/nw_strategy_arbiter.sv
// N-channel valid/ready arbiter with run-time selectable policy:
// fixed priority, round-robin or weighted round-robin.
// Ports: clk, rst_n (async low), mode_i, weights_i, in_valid_i,
// in_data_i, in_ready_o, out_valid_o, out_data_o, out_ch_o,
// out_ready_i, mode_active_o.
module nw_strategy_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode_i,
  input  logic [NUM_CH*WEIGHT_W-1:0] weights_i,
  input  logic [NUM_CH-1:0]          in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0]   in_data_i,
  output logic [NUM_CH-1:0]          in_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(NUM_CH)-1:0]  out_ch_o,
  input  logic                       out_ready_i,
  output logic [1:0]                 mode_active_o
);

  localparam int CH_W = $clog2(NUM_CH);

  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [CH_W-1:0]     r_ch;
  logic [1:0]          r_mode;
  logic [CH_W-1:0]     r_ptr;
  logic [WEIGHT_W-1:0] r_cnt;

  logic                w_load_en;
  logic                w_any;
  logic                w_xfer;
  logic                w_rr;
  logic                w_found;
  logic [CH_W-1:0]     w_idx;
  logic [CH_W-1:0]     w_gnt;
  logic [CH_W-1:0]     w_gnt_nxt;
  logic [WEIGHT_W-1:0] w_wt_raw;
  logic [WEIGHT_W-1:0] w_wt;
  logic [WEIGHT_W-1:0] w_c;
  logic                w_burst_end;

  // (p + k) mod NUM_CH; one extra bit holds the pre-wrap sum,
  // so non-power-of-two channel counts wrap correctly.
  function automatic logic [CH_W-1:0] f_wrap(
    input logic [CH_W-1:0] p,
    input int              k
  );
    logic [CH_W:0] s;
    s = {1'b0, p} + (CH_W+1)'(k);
    if (s >= (CH_W+1)'(NUM_CH))
      s = s - (CH_W+1)'(NUM_CH);
    return s[CH_W-1:0];
  endfunction

  assign w_load_en = !r_valid || out_ready_i;
  assign w_any     = |in_valid_i;
  assign w_xfer    = w_load_en && w_any;
  assign w_rr      = (r_mode == 2'd1) || (r_mode == 2'd2);

  // Priority search: from index 0 for fixed priority (and the
  // reserved mode), from r_ptr with wrap for the RR policies.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = w_rr ? f_wrap(r_ptr, k) : CH_W'(k);
      if (!w_found && in_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_wt_raw    = weights_i[int'(w_gnt)*WEIGHT_W +: WEIGHT_W];
  assign w_wt        = (w_wt_raw == '0) ? WEIGHT_W'(1) : w_wt_raw;
  assign w_c         = (w_gnt == r_ptr) ? r_cnt : '0;
  assign w_burst_end = (w_c >= (w_wt - WEIGHT_W'(1)));
  assign w_gnt_nxt   = f_wrap(w_gnt, 1);

  always_comb begin
    in_ready_o = '0;
    if (rst_n && w_xfer)
      in_ready_o[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_mode  <= 2'd0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= in_data_i[int'(w_gnt)*DATA_W +: DATA_W];
        r_ch    <= w_gnt;
        unique case (r_mode)
          2'd1: r_ptr <= w_gnt_nxt;
          2'd2: begin
            if (w_burst_end) begin
              r_ptr <= w_gnt_nxt;
              r_cnt <= '0;
            end else begin
              r_ptr <= w_gnt;
              r_cnt <= w_c + WEIGHT_W'(1);
            end
          end
          default: ;
        endcase
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end
      // Policy swaps only when fully drained and idle; this cannot
      // coincide with a transfer since no channel is valid.
      if (!r_valid && !w_any) begin
        r_mode <= mode_i;
        r_ptr  <= '0;
        r_cnt  <= '0;
      end
    end
  end

  assign out_valid_o   = r_valid;
  assign out_data_o    = r_data;
  assign out_ch_o      = r_ch;
  assign mode_active_o = r_mode;

endmodule

// File: tb/tb_nw_strategy_arbiter.sv
// Scoreboard bench for nw_strategy_arbiter.
// Directed phases push expected channels; a monitor pops and checks.
module tb_nw_strategy_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      mode_i = 2'd0;
  logic [N*WW-1:0] weights_i;
  logic [N-1:0]    in_valid_i = '0;
  logic [N*DW-1:0] in_data_i;
  logic [N-1:0]    in_ready_o;
  logic            out_valid_o;
  logic [DW-1:0]   out_data_o;
  logic [1:0]      out_ch_o;
  logic            out_ready_i = 1'b1;
  logic [1:0]      mode_active_o;

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  int unsigned exp_q[$];
  int unsigned e;

  nw_strategy_arbiter #(
    .NUM_CH(N), .DATA_W(DW), .WEIGHT_W(WW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_i(mode_i),
    .weights_i(weights_i),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o(out_data_o),
    .out_ch_o(out_ch_o),
    .out_ready_i(out_ready_i),
    .mode_active_o(mode_active_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, x);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int unsigned ch);
    exp_q.push_back(ch);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (|(in_valid_i & in_ready_o)) n_in++;
      if (out_valid_o && out_ready_i) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat: unexpected ch %0d", out_ch_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_ch", 32'(out_ch_o), e);
          chk("beat_data", out_data_o, 32'hA5A5_0001 + e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++)
      in_data_i[i*DW +: DW] = 32'hA5A5_0001 + 32'(i);
    weights_i = {4'd0, 4'd2, 4'd1, 4'd3};

    #2;
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_ready", 32'(in_ready_o), 0);
    chk("rst_mode", 32'(mode_active_o), 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_ch", 32'(out_ch_o), 0);
    #10 rst_n = 1'b1;
    cyc(1);

    // fixed priority
    in_valid_i = 4'hF;
    repeat (6) push(0);
    repeat (6) begin
      #3 chk("m0_ready", 32'(in_ready_o), 32'h1);
      cyc(1);
    end
    in_valid_i = '0;
    mode_i = 2'd1;
    cyc(3);
    chk("mode_rr", 32'(mode_active_o), 1);

    // round-robin
    in_valid_i = 4'hF;
    push(0); push(1); push(2); push(3);
    cyc(4);
    in_valid_i = 4'b1011;
    push(0); push(1); push(3); push(0); push(1); push(3);
    cyc(6);
    in_valid_i = '0;
    mode_i = 2'd2;
    cyc(3);
    chk("mode_wrr", 32'(mode_active_o), 2);

    // weighted RR
    in_valid_i = 4'hF;
    push(0); push(0); push(0); push(1); push(2);
    push(2); push(3); push(0); push(0); push(0);
    cyc(10);
    in_valid_i = '0;
    mode_i = 2'd0;
    cyc(3);
    chk("mode_fp", 32'(mode_active_o), 0);

    // backpressure
    out_ready_i = 1'b0;
    in_valid_i = 4'hF;
    push(0);
    cyc(1);
    repeat (5) begin
      #3;
      chk("bp_valid", 32'(out_valid_o), 1);
      chk("bp_data", out_data_o, 32'hA5A5_0001);
      chk("bp_ch", 32'(out_ch_o), 0);
      chk("bp_ready", 32'(in_ready_o), 0);
      cyc(1);
    end
    out_ready_i = 1'b1;
    repeat (3) push(0);
    cyc(3);
    in_valid_i = '0;
    cyc(2);
    chk("bp_count", n_in, n_out);
    chk("bp_qempty", exp_q.size(), 0);

    // deferred mode change
    mode_i = 2'd1;
    in_valid_i = 4'hF;
    repeat (4) push(0);
    repeat (4) begin
      #3 chk("defer_busy", 32'(mode_active_o), 0);
      cyc(1);
    end
    in_valid_i = '0;
    cyc(1);
    chk("defer_drain", 32'(mode_active_o), 0);
    cyc(1);
    chk("defer_done", 32'(mode_active_o), 1);
    in_valid_i = 4'hF;
    push(0); push(1); push(2);
    cyc(3);
    in_valid_i = '0;
    mode_i = 2'd2;
    cyc(3);
    chk("mode_wrr2", 32'(mode_active_o), 2);

    // async reset mid-burst; the held beat is dropped
    in_valid_i = 4'hF;
    push(0);
    cyc(2);
    #1 rst_n = 1'b0;
    #1;
    in_valid_i = 4'b0110;
    mode_i = 2'd0;
    chk("arst_valid", 32'(out_valid_o), 0);
    chk("arst_ready", 32'(in_ready_o), 0);
    n_in = 0;
    n_out = 0;
    #10 rst_n = 1'b1;
    #1;
    chk("post_mode", 32'(mode_active_o), 0);
    chk("post_ready", 32'(in_ready_o), 32'h2);
    push(1);
    cyc(1);
    in_valid_i = '0;
    cyc(3);
    chk("post_count", n_in, n_out);
    chk("final_qempty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
